wbuf_coalesce: RTL and testbench

//  Parametrised write buffer for the data-side memory path. It queues cache write-throughs
//  ({adr,data,byteen}) and drains them to external memory in FIFO order. It merges a write

---
 rtl/wbuf_coalesce_if.sv | 35 +++
 rtl/wbuf_coalesce.sv | 148 ++++++++++++++
 tb/tb_wbuf_coalesce.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbuf_coalesce_if.sv
// Bus bundle for the coalescing write buffer: write request side, read probe,
// memory drain side and occupancy status. The buffer itself uses the slave view.
interface wbuf_coalesce_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 27,
    parameter int DW    = 32,
    parameter int BW    = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [BW-1:0] byteen;
    logic          en;
    logic          done;
    logic [AW-1:0] probeadr;
    logic          probehit;
    logic [AW-1:0] memadr;
    logic [DW-1:0] memdata;
    logic [BW-1:0] membyteen;
    logic          memen;
    logic          memdone;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output adr, data, byteen, en, probeadr, memdone,
        input  done, probehit, memadr, memdata, membyteen, memen, empty, count
    );

    modport slave (
        input  adr, data, byteen, en, probeadr, memdone,
        output done, probehit, memadr, memdata, membyteen, memen, empty, count
    );
endinterface

// File: rtl/wbuf_coalesce.sv
// Write buffer for the data-side memory path. Cache write-throughs are queued
// in a circular array and drained to memory in FIFO order; a write to the same
// word as the youngest non-head entry is merged byte-wise into that entry.
// A combinational probe reports whether an address has a pending store.
// Queue state advances on ph1; the memory-side outputs are re-registered on ph2.
module wbuf_coalesce #(
    parameter int DEPTH = 4,
    parameter int AW    = 27,
    parameter int DW    = 32,
    parameter int BW    = 4,
    parameter int MERGE = 1
) (
    input  logic            ph1,
    input  logic            ph2,
    input  logic            reset,
    wbuf_coalesce_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    ent_adr  [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [BW-1:0]    ent_be   [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    tailm1;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             empty_r;

    logic             full;
    logic             mergeok;
    logic             accept;
    logic             push;
    logic             pop;
    logic             hit;

    logic             memen_r;
    logic [AW-1:0]    memadr_r;
    logic [DW-1:0]    memdata_r;
    logic [BW-1:0]    membyteen_r;

    // Overlay the enabled bytes of a new write onto an existing entry's data.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_d,
                                                  input logic [DW-1:0] wr_d,
                                                  input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) begin
                r[b*8 +: 8] = wr_d[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // The youngest entry sits one behind tail. It is only a merge target when at
    // least two entries are queued, so the head (possibly on the memory bus) is
    // never modified under the memory controller.
    assign tailm1  = tail - 1'b1;
    assign mergeok = (MERGE != 0) && (count >= CW'(2)) && (bus.adr == ent_adr[tailm1]);

    // full comes from the registered count only, so done never depends on memdone.
    assign full    = (count == CW'(DEPTH));
    assign accept  = bus.en && (mergeok || !full);
    assign push    = accept && !mergeok;

    // A memdone without a valid head entry is ignored.
    assign pop     = valid[head] && bus.memdone;

    // Next occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Probe every valid entry for a pending store to probeadr.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (ent_adr[i] == bus.probeadr)) begin
                hit = 1'b1;
            end
        end
    end

    // Entry storage: merge into the youngest entry or fill the tail slot.
    // Writes are suppressed during reset so discarded requests leave no trace.
    always_ff @(posedge ph1) begin
        if (!reset && accept) begin
            if (mergeok) begin
                ent_data[tailm1] <= merge_bytes(ent_data[tailm1], bus.data, bus.byteen);
                ent_be[tailm1]   <= ent_be[tailm1] | bus.byteen;
            end else begin
                ent_adr[tail]    <= bus.adr;
                ent_data[tail]   <= bus.data;
                ent_be[tail]     <= bus.byteen;
            end
        end
    end

    // Queue control: pointers, valid bits, occupancy and registered empty flag.
    always_ff @(posedge ph1) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            empty_r <= 1'b1;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count   <= count_nxt;
            empty_r <= (count_nxt == '0);
        end
    end

    // Memory-side outputs follow the head entry half a cycle after ph1 so they
    // are settled for the controller; pops use valid[head] directly, which is
    // the same value these registers present by the time memdone is sampled.
    always_ff @(posedge ph2) begin
        memen_r     <= valid[head];
        memadr_r    <= ent_adr[head];
        memdata_r   <= ent_data[head];
        membyteen_r <= ent_be[head];
    end

    assign bus.done      = reset || accept;
    assign bus.probehit  = hit;
    assign bus.memen     = memen_r;
    assign bus.memadr    = memadr_r;
    assign bus.memdata   = memdata_r;
    assign bus.membyteen = membyteen_r;
    assign bus.empty     = empty_r;
    assign bus.count     = count;
endmodule

// File: tb/tb_wbuf_coalesce.sv
// Bench for wbuf_coalesce: a coalescing instance and a plain-FIFO instance share
// one stimulus stream. A queue model per instance predicts every output each
// cycle; directed sequences add literal expectations.
module tb_wbuf_coalesce;
    localparam int DEPTH = 4;
    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int CW    = 3;

    logic          ph1 = 1'b0;
    logic          ph2 = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] data = '0;
    logic [BW-1:0] byteen = '0;
    logic          en = 1'b0;
    logic          memdone = 1'b0;
    logic [AW-1:0] probeadr = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } ent_t;

    ent_t mq[2][$];
    bit   armed = 1'b0;

    wbuf_coalesce_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BW(BW)) bm_if ();
    wbuf_coalesce_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BW(BW)) bp_if ();

    assign bm_if.adr = adr;      assign bp_if.adr = adr;
    assign bm_if.data = data;    assign bp_if.data = data;
    assign bm_if.byteen = byteen; assign bp_if.byteen = byteen;
    assign bm_if.en = en;        assign bp_if.en = en;
    assign bm_if.memdone = memdone; assign bp_if.memdone = memdone;
    assign bm_if.probeadr = probeadr; assign bp_if.probeadr = probeadr;

    wbuf_coalesce #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BW(BW), .MERGE(1)) u_merge (
        .ph1(ph1), .ph2(ph2), .reset(reset), .bus(bm_if.slave)
    );
    wbuf_coalesce #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BW(BW), .MERGE(0)) u_plain (
        .ph1(ph1), .ph2(ph2), .reset(reset), .bus(bp_if.slave)
    );

    // Two non-overlapping phases, period 10: ph1 rises at 1, ph2 rises at 6.
    initial begin
        forever begin
            #1 ph1 = 1'b1;
            #4 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #3 ph2 = 1'b0;
            #1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after ph1, then return at the sample point.
    task automatic cyc(input logic r, input logic e, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b,
                       input logic md, input logic [AW-1:0] pa);
        @(posedge ph1);
        #1;
        reset = r; en = e; adr = a; data = d; byteen = b; memdone = md; probeadr = pa;
        @(posedge ph2);
        #2;
    endtask

    task automatic idle(input logic md, input logic [AW-1:0] pa);
        cyc(1'b0, 1'b0, '0, '0, '0, md, pa);
    endtask

    // Model/compare process: checks outputs against the queue model at each
    // sample point, then applies this cycle's inputs to the model.
    logic          g_done, g_hit, g_memen, g_empty;
    logic [AW-1:0] g_madr;
    logic [DW-1:0] g_mdata;
    logic [BW-1:0] g_mbe;
    logic [CW-1:0] g_count;
    int            m_sz;
    bit            m_merge, m_acc, m_pop, m_hit, m_done;
    ent_t          m_t;
    logic [DW-1:0] m_mask;
    string         pfx;

    initial begin
        forever begin
            @(posedge ph2);
            #2;
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    g_done = bm_if.done; g_hit = bm_if.probehit; g_memen = bm_if.memen;
                    g_empty = bm_if.empty; g_madr = bm_if.memadr; g_mdata = bm_if.memdata;
                    g_mbe = bm_if.membyteen; g_count = bm_if.count; pfx = "m.";
                end else begin
                    g_done = bp_if.done; g_hit = bp_if.probehit; g_memen = bp_if.memen;
                    g_empty = bp_if.empty; g_madr = bp_if.memadr; g_mdata = bp_if.memdata;
                    g_mbe = bp_if.membyteen; g_count = bp_if.count; pfx = "p.";
                end
                m_sz    = mq[k].size();
                m_merge = (k == 0) && (m_sz >= 2) && (mq[k][m_sz-1].adr == adr);
                m_acc   = en && (m_merge || (m_sz < DEPTH));
                m_done  = reset || m_acc;
                m_pop   = (m_sz > 0) && memdone;
                m_hit   = 1'b0;
                for (int i = 0; i < m_sz; i++) begin
                    if (mq[k][i].adr == probeadr) m_hit = 1'b1;
                end
                if (armed) begin
                    chk({pfx, "done"},     64'(g_done),  64'(m_done));
                    chk({pfx, "probehit"}, 64'(g_hit),   64'(m_hit));
                    chk({pfx, "count"},    64'(g_count), 64'(m_sz));
                    chk({pfx, "empty"},    64'(g_empty), 64'(m_sz == 0));
                    chk({pfx, "memen"},    64'(g_memen), 64'(m_sz > 0));
                    if (m_sz > 0) begin
                        chk({pfx, "memadr"},    64'(g_madr),  64'(mq[k][0].adr));
                        chk({pfx, "memdata"},   64'(g_mdata), 64'(mq[k][0].data));
                        chk({pfx, "membyteen"}, 64'(g_mbe),   64'(mq[k][0].be));
                    end
                end
                if (reset) begin
                    mq[k].delete();
                end else begin
                    if (m_acc && m_merge) begin
                        for (int b = 0; b < BW; b++) m_mask[b*8 +: 8] = {8{byteen[b]}};
                        m_t      = mq[k][m_sz-1];
                        m_t.data = (m_t.data & ~m_mask) | (data & m_mask);
                        m_t.be   = m_t.be | byteen;
                        mq[k][m_sz-1] = m_t;
                    end
                    if (m_pop) void'(mq[k].pop_front());
                    if (m_acc && !m_merge) begin
                        m_t.adr = adr; m_t.data = data; m_t.be = byteen;
                        mq[k].push_back(m_t);
                    end
                end
            end
            if (reset) armed = 1'b1;
        end
    end

    initial begin
        // Reset, then idle
        cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        cyc(1'b1, 1'b1, 27'h3, 32'h1, 4'h1, 1'b0, '0);
        chk("reset_done", 64'(bm_if.done), 64'd1);
        idle(1'b0, 27'h10);
        chk("idle_memen", 64'(bm_if.memen), 64'd0);
        chk("idle_empty", 64'(bm_if.empty), 64'd1);
        chk("idle_count", 64'(bm_if.count), 64'd0);
        chk("idle_probehit", 64'(bm_if.probehit), 64'd0);

        // Single write into an empty buffer, then one memdone pulse
        cyc(1'b0, 1'b1, 27'h10, 32'hAAAA5555, 4'hF, 1'b0, '0);
        chk("single_done", 64'(bm_if.done), 64'd1);
        idle(1'b0, '0);
        chk("single_memen", 64'(bm_if.memen), 64'd1);
        chk("single_memadr", 64'(bm_if.memadr), 64'h10);
        chk("single_memdata", 64'(bm_if.memdata), 64'hAAAA5555);
        chk("single_count", 64'(bm_if.count), 64'd1);
        idle(1'b1, '0);
        idle(1'b0, '0);
        chk("single_count_after", 64'(bm_if.count), 64'd0);
        chk("single_memen_after", 64'(bm_if.memen), 64'd0);

        // Fill to DEPTH, fifth write stalls until a pop frees a slot
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b1, AW'(i), 32'(i * 256), 4'hF, 1'b0, '0);
            chk("fill_done", 64'(bm_if.done), 64'd1);
        end
        cyc(1'b0, 1'b1, 27'h5, 32'h500, 4'hF, 1'b0, '0);
        chk("full_count", 64'(bm_if.count), 64'd4);
        chk("full_done", 64'(bm_if.done), 64'd0);
        cyc(1'b0, 1'b1, 27'h5, 32'h500, 4'hF, 1'b1, '0);
        chk("full_pop_done", 64'(bm_if.done), 64'd0);
        chk("full_head", 64'(bm_if.memadr), 64'd1);
        cyc(1'b0, 1'b1, 27'h5, 32'h500, 4'hF, 1'b0, '0);
        chk("full_retry_done", 64'(bm_if.done), 64'd1);
        for (int i = 2; i <= 5; i++) begin
            idle(1'b1, '0);
            chk("drain_order", 64'(bm_if.memadr), 64'(i));
        end
        idle(1'b0, '0);
        chk("drain_count", 64'(bm_if.count), 64'd0);

        // Coalescing into the youngest entry versus plain FIFO
        cyc(1'b0, 1'b1, 27'h5, 32'h11111111, 4'b0001, 1'b0, '0);
        cyc(1'b0, 1'b1, 27'h7, 32'h00000000, 4'b0011, 1'b0, '0);
        cyc(1'b0, 1'b1, 27'h7, 32'hDEADBEEF, 4'b1100, 1'b0, '0);
        chk("merge_done", 64'(bm_if.done), 64'd1);
        idle(1'b0, '0);
        chk("merge_count", 64'(bm_if.count), 64'd2);
        chk("plain_count", 64'(bp_if.count), 64'd3);
        idle(1'b1, '0);
        chk("merge_head", 64'(bm_if.memadr), 64'd5);
        idle(1'b0, '0);
        chk("merge_adr", 64'(bm_if.memadr), 64'd7);
        chk("merge_data", 64'(bm_if.memdata), 64'hDEAD0000);
        chk("merge_be", 64'(bm_if.membyteen), 64'hF);
        chk("plain_data", 64'(bp_if.memdata), 64'h0);
        chk("plain_be", 64'(bp_if.membyteen), 64'h3);
        repeat (3) idle(1'b1, '0);
        idle(1'b0, '0);
        chk("merge_drained", 64'(bm_if.count), 64'd0);
        chk("plain_drained", 64'(bp_if.count), 64'd0);

        // Head entry is never a merge target; probe sees pending stores
        cyc(1'b0, 1'b1, 27'h9, 32'h1, 4'hF, 1'b0, '0);
        cyc(1'b0, 1'b1, 27'h9, 32'h2, 4'hF, 1'b0, '0);
        chk("head_count1", 64'(bm_if.count), 64'd1);
        idle(1'b0, 27'h9);
        chk("head_nomerge", 64'(bm_if.count), 64'd2);
        chk("probe_hit", 64'(bm_if.probehit), 64'd1);
        idle(1'b1, 27'h9);
        idle(1'b1, 27'h9);
        idle(1'b0, 27'h9);
        chk("probe_clear", 64'(bm_if.probehit), 64'd0);
        chk("probe_count", 64'(bm_if.count), 64'd0);

        // Reset while full and draining
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, AW'(20 + i), 32'(i), 4'hF, 1'b0, '0);
        idle(1'b0, '0);
        chk("rst_pre_memen", 64'(bm_if.memen), 64'd1);
        chk("rst_pre_count", 64'(bm_if.count), 64'd4);
        cyc(1'b1, 1'b1, 27'h30, 32'h3, 4'hF, 1'b1, '0);
        chk("rst_mid_done", 64'(bm_if.done), 64'd1);
        idle(1'b0, '0);
        chk("rst_count", 64'(bm_if.count), 64'd0);
        chk("rst_memen", 64'(bm_if.memen), 64'd0);
        chk("rst_empty", 64'(bm_if.empty), 64'd1);
        idle(1'b1, '0);
        idle(1'b1, '0);
        chk("rst_ignored_count", 64'(bm_if.count), 64'd0);
        chk("rst_ignored_memen", 64'(bm_if.memen), 64'd0);

        // Randomized traffic on a small address set to exercise merges and probes
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 6),
                AW'($urandom_range(0, 5)),
                32'($urandom),
                BW'($urandom_range(0, 15)),
                ($urandom_range(0, 9) < 4),
                AW'($urandom_range(0, 6)));
        end
        for (int n = 0; n < 8; n++) idle(1'b1, '0);
        idle(1'b0, '0);
        @(posedge ph1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
